// File: rtl/simd_output_writer.sv
// simd_output_writer: buffers 4-lane result vectors from the SIMD core and writes
// them as packed 32-bit words into a row-major destination image RAM.
module simd_output_writer #(
  parameter int ADDR_W     = 16,
  parameter int DIM_W      = 12,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [DIM_W-1:0]  i_out_width,
  input  logic [DIM_W-1:0]  i_out_height,
  input  logic [3:0][7:0]   i_pixel_vec,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_be,
  input  logic              i_mem_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  stride_q, stride_d, height_q, height_d;
  logic [DIM_W-1:0]  col_q, col_d, row_q, row_d;
  logic [1:0]        rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [31:0]       mem_d [FIFO_DEPTH];

  logic             push_s, pop_s, last_col_s, last_word_s, zero_size_s;
  logic [DIM_W:0]   width_p3_s;
  logic [3:0]       be_s;

  assign o_ready     = (state_q == S_RUN) && (count_q < DEPTH_C);
  assign o_mem_we    = (state_q == S_RUN) && (count_q != '0);
  assign push_s      = i_valid && o_ready;
  assign pop_s       = o_mem_we && i_mem_ready;
  assign last_col_s  = (col_q == stride_q - DIM_W'(1));
  assign last_word_s = last_col_s && (row_q == height_q - DIM_W'(1));
  assign zero_size_s = (i_out_width == '0) || (i_out_height == '0);
  assign width_p3_s  = {1'b0, i_out_width} + (DIM_W+1)'(3);
  // Only the last word of a row with a partial vector masks its upper lanes
  assign be_s        = (last_col_s && (rem_q != 2'd0)) ? ((4'b0001 << rem_q) - 4'b0001) : 4'hF;

  assign o_mem_addr  = o_mem_we ? addr_q : '0;
  assign o_mem_wdata = o_mem_we ? mem_q[rd_ptr_q] : 32'd0;
  assign o_mem_be    = o_mem_we ? be_s : 4'd0;
  assign o_busy      = (state_q == S_RUN);
  assign o_done      = (state_q == S_DONE);
  assign o_overflow  = overflow_q;

  // Next-state, FIFO bookkeeping and address generation
  always_comb begin
    state_d    = state_q;
    stride_d   = stride_q;
    height_d   = height_q;
    rem_d      = rem_q;
    col_d      = col_q;
    row_d      = row_q;
    addr_d     = addr_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    overflow_d = overflow_q | (i_valid & ~o_ready);

    if (push_s) begin
      mem_d[wr_ptr_q] = i_pixel_vec;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    // The linear word address equals base + row*stride + col, so it simply increments
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      addr_d   = addr_q + ADDR_W'(1);
      col_d    = last_col_s ? '0 : col_q + DIM_W'(1);
      row_d    = last_col_s ? row_q + DIM_W'(1) : row_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          stride_d   = DIM_W'(width_p3_s >> 2);
          rem_d      = i_out_width[1:0];
          height_d   = i_out_height;
          addr_d     = i_base_addr;
          col_d      = '0;
          row_d      = '0;
          count_d    = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          overflow_d = 1'b0;
          state_d    = zero_size_s ? S_DONE : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Anything still buffered after the final word lies outside the frame
        if (pop_s && last_word_s) begin
          state_d  = S_DONE;
          count_d  = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      stride_q   <= '0;
      height_q   <= '0;
      rem_q      <= 2'd0;
      col_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      overflow_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      stride_q   <= stride_d;
      height_q   <= height_d;
      rem_q      <= rem_d;
      col_q      <= col_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Vector storage; contents are only observed while count is non-zero
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: doc/simd_output_writer.md
Name: simd_output_writer

Overview:
Downstream stage of the 4-lane bilinear interpolation core (bilinear_interp_simd). Each cycle that core asserts o_valid, this block captures the 4×8-bit result vector into a small FIFO. It packs the vector into one 32-bit word and writes it to the destination image RAM with a row/column address generator. It handles frame start/done, memory backpressure, partial last vectors per row, and overflow detection.

Parameters:
ADDR_W, 16, word-address width of destination RAM
DIM_W, 12, width of output image width/height fields
FIFO_DEPTH, 2, result-vector buffer entries (power of 2, ≥2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
i_start  in  1  frame start pulse; honoured only in IDLE
i_base_addr  in  ADDR_W  destination word address of pixel (0,0)
i_out_width  in  DIM_W  output pixels per row
i_out_height  in  DIM_W  output rows
i_pixel_vec  in  4×8 ([3:0][7:0])  lane results from SIMD core
i_valid  in  1  i_pixel_vec valid (single-cycle pulse per vector)
o_ready  out  1  FIFO can accept a vector this cycle
o_mem_we  out  1  write request
o_mem_addr  out  ADDR_W  write word address
o_mem_wdata  out  32  packed word; lane k at bits [8k+7:8k]
o_mem_be  out  4  byte enables; bit k = lane k
i_mem_ready  in  1  RAM accepts the write when o_mem_we && i_mem_ready
o_busy  out  1  high in RUN
o_done  out  1  one-cycle pulse when frame complete
o_overflow  out  1  sticky: vector arrived when not accepted

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE; FIFO empty; counters 0; all outputs 0 (o_mem_addr=0, o_mem_wdata=0, o_mem_be=0, o_overflow=0). Reset mid-frame aborts immediately; any pending write is dropped.
- FSM IDLE→RUN: on i_start. Latch base, width, height. Clear o_overflow and counters. stride = ceil(width/4) words; rem = width mod 4.
- If width==0 or height==0: IDLE→DONE, o_done pulses next cycle, no writes.
- RUN→DONE: when the final word (row=height-1, col=stride-1) is accepted by RAM. DONE→IDLE unconditionally after 1 cycle; o_done=1 only in DONE.
- i_start in RUN/DONE: ignored.
- o_ready = (state==RUN) && (count < FIFO_DEPTH). Push when i_valid && o_ready. i_valid && !o_ready sets o_overflow and drops the vector, including in IDLE/DONE.
- Simultaneous push and pop when full: push refused, because o_ready is computed from registered count. Simultaneous push and pop otherwise: count unchanged.
- Write port: o_mem_we=1 whenever FIFO non-empty in RUN. Head entry drives wdata. addr = base + row*stride + col. addr/wdata/be held stable until i_mem_ready. Pop on o_mem_we && i_mem_ready.
- Latency: vector pushed at edge N → o_mem_we visible after edge N (same cycle the entry becomes head if FIFO was empty). Sustained throughput is 1 vector/cycle with i_mem_ready=1.
- Address counters advance on each accepted write: col+1; at col==stride-1 → col=0, row+1. Address arithmetic is modulo 2^ADDR_W (wrap, no error).
- Byte enables: 4'hF, except when col==stride-1 and rem≠0, then be=(1<<rem)-1 (rem=1→0001, 2→0011, 3→0111). Masked lanes still appear in wdata.
- Vectors pushed beyond width×height coverage cannot be written: after DONE, o_ready=0 and they count as overflow.

Test Plan:
- Basic: base=0x100, width=8, height=2; 4 vectors, lanes {15,25,35,45} each, i_mem_ready=1 → writes at 0x100,0x101,0x102,0x103, wdata=0x2D23190F, be=F; o_done pulses 1 cycle after the 4th write; o_busy falls.
- Partial row: width=6, height=2, base=0 → 4 writes at 0,1,2,3; be=F,3,F,3.
- Backpressure: width=12, height=1; i_mem_ready=0 for 6 cycles; 3 back-to-back i_valid → first two buffered, o_ready=0, third sets o_overflow=1; addr 0 and wdata stable throughout the stall; after release, 2 writes at 0,1; no o_done (frame incomplete); next i_start is ignored while in RUN.
- Zero size: i_start with width=0, height=5 → no o_mem_we; o_done one cycle later; state IDLE.
- Reset mid-frame: width=16, height=4; rst=1 after 3 writes → next cycle o_mem_we=0, o_busy=0, o_overflow=0. New i_start with base=0x200 → first write at 0x200.
- Overflow clear: set o_overflow via i_valid in IDLE, then i_start → o_overflow=0 in the cycle after.
